// File: rtl/led_pattern_sequencer_if.sv
// Control and status bundle between the key/host side and led_pattern_sequencer.
// The master drives the mode controls and pause. The slave (the sequencer) drives mode, tick and LEDs.
`timescale 1ns/1ps
interface led_pattern_sequencer_if;
    logic       mode_next;
    logic       mode_load;
    logic [1:0] mode_in;
    logic       pause;
    logic [1:0] mode;
    logic       tick;
    logic [3:0] led;

    modport master (
        output mode_next,
        output mode_load,
        output mode_in,
        output pause,
        input  mode,
        input  tick,
        input  led
    );

    modport slave (
        input  mode_next,
        input  mode_load,
        input  mode_in,
        input  pause,
        output mode,
        output tick,
        output led
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Four-LED sequencer with OFF / PWM breathing / running light / blink modes.
// It owns the tick divider, a free-running PWM counter and the per-mode sequencing state.
`timescale 1ns/1ps
module led_pattern_sequencer #(
    parameter int TICK_DIV    = 195_312,
    parameter int PWM_BITS    = 8,
    parameter int RUN_TICKS   = 64,
    parameter int BLINK_TICKS = 128,
    parameter int RESET_MODE  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    led_pattern_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BREATHE = 2'd1,
        MODE_RUN     = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STEP_MAX = (RUN_TICKS > BLINK_TICKS) ? RUN_TICKS : BLINK_TICKS;
    localparam int SCW      = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

    localparam logic [TCW-1:0]      TICK_LAST  = TCW'(TICK_DIV - 1);
    localparam logic [SCW-1:0]      RUN_LAST   = SCW'(RUN_TICKS - 1);
    localparam logic [SCW-1:0]      BLINK_LAST = SCW'(BLINK_TICKS - 1);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX  = '1;
    localparam mode_t               MODE_RESET = mode_t'(2'(RESET_MODE));

    mode_t               r_mode;
    logic [TCW-1:0]      r_tick_cnt;
    logic [SCW-1:0]      r_step_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_level;
    dir_t                r_dir;
    logic [3:0]          r_pattern;
    logic                r_blink_on;
    logic [3:0]          r_led;

    mode_t               w_mode_nxt;
    logic [TCW-1:0]      w_tick_cnt_nxt;
    logic [SCW-1:0]      w_step_cnt_nxt;
    logic [PWM_BITS-1:0] w_level_nxt;
    dir_t                w_dir_nxt;
    logic [3:0]          w_pattern_nxt;
    logic                w_blink_on_nxt;
    logic [3:0]          w_led_nxt;
    logic                w_tick;
    logic                w_restart;

    // Tick is combinational so that raising pause suppresses it in the same cycle.
    assign w_tick    = (r_tick_cnt == TICK_LAST) && !bus.pause;
    assign w_restart = bus.mode_load || bus.mode_next;

    assign bus.mode = r_mode;
    assign bus.tick = w_tick;
    assign bus.led  = r_led;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= MODE_RESET;
            r_tick_cnt <= '0;
            r_step_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_level    <= '0;
            r_dir      <= DIR_UP;
            r_pattern  <= 4'b0001;
            r_blink_on <= 1'b1;
            r_led      <= 4'b0000;
        end else begin
            r_mode     <= w_mode_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            r_level    <= w_level_nxt;
            r_dir      <= w_dir_nxt;
            r_pattern  <= w_pattern_nxt;
            r_blink_on <= w_blink_on_nxt;
            r_led      <= w_led_nxt;
        end
    end

    always_comb begin
        w_mode_nxt     = r_mode;
        w_tick_cnt_nxt = r_tick_cnt;
        w_step_cnt_nxt = r_step_cnt;
        w_level_nxt    = r_level;
        w_dir_nxt      = r_dir;
        w_pattern_nxt  = r_pattern;
        w_blink_on_nxt = r_blink_on;
        w_led_nxt      = 4'b0000;

        // The LED stage reads the state before this edge, so a new mode shows one clock later.
        case (r_mode)
            MODE_BREATHE: w_led_nxt = {4{r_pwm_cnt < r_level}};
            MODE_RUN:     w_led_nxt = r_pattern;
            MODE_BLINK:   w_led_nxt = {4{r_blink_on}};
            default:      w_led_nxt = 4'b0000;
        endcase

        if (!bus.pause) begin
            w_tick_cnt_nxt = (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
        end

        if (w_tick) begin
            case (r_mode)
                MODE_BREATHE: begin
                    // The direction flips on the same tick that reaches an extreme, so there is no plateau.
                    if (r_dir == DIR_UP) begin
                        w_level_nxt = r_level + 1'b1;
                        if (w_level_nxt == LEVEL_MAX) w_dir_nxt = DIR_DOWN;
                    end else begin
                        w_level_nxt = r_level - 1'b1;
                        if (w_level_nxt == '0) w_dir_nxt = DIR_UP;
                    end
                end
                MODE_RUN: begin
                    if (r_step_cnt == RUN_LAST) begin
                        w_step_cnt_nxt = '0;
                        w_pattern_nxt  = {r_pattern[2:0], r_pattern[3]};
                    end else begin
                        w_step_cnt_nxt = r_step_cnt + 1'b1;
                    end
                end
                MODE_BLINK: begin
                    if (r_step_cnt == BLINK_LAST) begin
                        w_step_cnt_nxt = '0;
                        w_blink_on_nxt = !r_blink_on;
                    end else begin
                        w_step_cnt_nxt = r_step_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // A load of the same value also restarts sequencing. The load takes priority over the step.
        if (w_restart) begin
            w_mode_nxt     = bus.mode_load ? mode_t'(bus.mode_in) : mode_t'(r_mode + 2'd1);
            w_tick_cnt_nxt = '0;
            w_step_cnt_nxt = '0;
            w_level_nxt    = '0;
            w_dir_nxt      = DIR_UP;
            w_pattern_nxt  = 4'b0001;
            w_blink_on_nxt = 1'b1;
        end
    end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer. A behavioural model feeds a per-cycle scoreboard.
// Scenario tasks add directed checks on the timing and priority rules.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;
    localparam int TD   = 4;
    localparam int PB   = 3;
    localparam int RT   = 2;
    localparam int BT   = 3;
    localparam int RM   = 1;
    localparam int LMAX = (1 << PB) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    led_pattern_sequencer_if bus();

    led_pattern_sequencer #(
        .TICK_DIV   (TD),
        .PWM_BITS   (PB),
        .RUN_TICKS  (RT),
        .BLINK_TICKS(BT),
        .RESET_MODE (RM)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: breathing is tracked as a position on a triangle of period 2*LMAX ticks.
    int         mMode, mTick, mPwm, mPhase, mSteps, mRunIdx;
    bit         mBlink;
    logic [3:0] mLed;
    logic [6:0] sbQ[$];

    task automatic model_reset();
        mMode = RM; mTick = 0; mPwm = 0; mPhase = 0;
        mSteps = 0; mRunIdx = 0; mBlink = 1'b1; mLed = 4'b0000;
    endtask

    task automatic model_step();
        bit tickNow;
        int lvl;
        tickNow = (mTick == TD - 1) && !bus.pause;
        lvl = (mPhase <= LMAX) ? mPhase : 2 * LMAX - mPhase;
        case (mMode)
            1:       mLed = (mPwm < lvl) ? 4'hF : 4'h0;
            2:       mLed = 4'(1 << mRunIdx);
            3:       mLed = mBlink ? 4'hF : 4'h0;
            default: mLed = 4'h0;
        endcase
        mPwm = (mPwm + 1) % (1 << PB);
        if (bus.mode_load || bus.mode_next) begin
            mMode = bus.mode_load ? int'(bus.mode_in) : (mMode + 1) % 4;
            mTick = 0; mPhase = 0; mSteps = 0; mRunIdx = 0; mBlink = 1'b1;
        end else begin
            if (!bus.pause) mTick = (mTick + 1) % TD;
            if (tickNow) begin
                case (mMode)
                    1: mPhase = (mPhase + 1) % (2 * LMAX);
                    2: begin
                        mSteps++;
                        if (mSteps == RT) begin mSteps = 0; mRunIdx = (mRunIdx + 1) % 4; end
                    end
                    3: begin
                        mSteps++;
                        if (mSteps == BT) begin mSteps = 0; mBlink = !mBlink; end
                    end
                    default: begin end
                endcase
            end
        end
    endtask

    initial model_reset();
    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        bit eTick;
        if (!rst_n) model_reset();
        else model_step();
        eTick = (mTick == TD - 1) && !bus.pause;
        sbQ.push_back({mMode[1:0], mLed, eTick});
    end

    always @(posedge clk) begin
        logic [6:0] expv;
        #1;
        checks++;
        if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty at %0t", $time);
        end else begin
            expv = sbQ.pop_front();
            if ({bus.mode, bus.led, bus.tick} !== expv) begin
                errors++;
                $display("[TB] FAIL scoreboard at %0t: mode/led/tick actual=%b/%b/%b required=%b/%b/%b",
                         $time, bus.mode, bus.led, bus.tick, expv[6:5], expv[4:1], expv[0]);
            end
        end
    end

    task automatic wait_change(input logic [3:0] from, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.led === from && n < 64);
    endtask

    task automatic test_reset();
        int gap;
        bus.mode_next = 1'b0; bus.mode_load = 1'b0; bus.mode_in = 2'd0; bus.pause = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mode !== 2'd1) begin errors++; $display("[TB] FAIL reset_mode: actual=%0d required=1", bus.mode); end
        checks++;
        if (bus.led !== 4'b0000) begin errors++; $display("[TB] FAIL reset_led: actual=%b required=0000", bus.led); end
        checks++;
        if (bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: actual=%b required=0", bus.tick); end
        rst_n = 1'b1;
        gap = 0;
        do begin @(negedge clk); gap++; end while (bus.tick !== 1'b1 && gap < 20);
        checks++;
        if (gap != TD - 1) begin errors++; $display("[TB] FAIL first_tick_gap: actual=%0d required=%0d", gap, TD - 1); end
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            do begin @(negedge clk); gap++; end while (bus.tick !== 1'b1 && gap < 20);
            checks++;
            if (gap != TD) begin errors++; $display("[TB] FAIL tick_period: actual=%0d required=%0d", gap, TD); end
        end
        repeat (16 * TD) @(negedge clk);
    endtask

    task automatic test_run();
        logic [3:0] seq[4];
        logic [3:0] prev;
        int n;
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.mode_next = 1'b1;
        @(negedge clk);
        bus.mode_next = 1'b0;
        checks++;
        if (bus.mode !== 2'd2) begin errors++; $display("[TB] FAIL run_mode: actual=%0d required=2", bus.mode); end
        @(negedge clk);
        checks++;
        if (bus.led !== 4'b0001) begin errors++; $display("[TB] FAIL run_first_led: actual=%b required=0001", bus.led); end
        prev = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            wait_change(prev, n);
            checks++;
            if (n != 8) begin errors++; $display("[TB] FAIL run_shift_gap: actual=%0d required=8", n); end
            checks++;
            if (bus.led !== seq[k]) begin errors++; $display("[TB] FAIL run_pattern: actual=%b required=%b", bus.led, seq[k]); end
            prev = seq[k];
        end
    endtask

    task automatic test_blink();
        int n;
        bus.mode_next = 1'b1;
        @(negedge clk);
        bus.mode_next = 1'b0;
        checks++;
        if (bus.mode !== 2'd3) begin errors++; $display("[TB] FAIL blink_mode: actual=%0d required=3", bus.mode); end
        @(negedge clk);
        checks++;
        if (bus.led !== 4'b1111) begin errors++; $display("[TB] FAIL blink_first_led: actual=%b required=1111", bus.led); end
        wait_change(4'b1111, n);
        checks++;
        if (n != 12) begin errors++; $display("[TB] FAIL blink_on_len: actual=%0d required=12", n); end
        checks++;
        if (bus.led !== 4'b0000) begin errors++; $display("[TB] FAIL blink_off_led: actual=%b required=0000", bus.led); end
        wait_change(4'b0000, n);
        checks++;
        if (n != 12) begin errors++; $display("[TB] FAIL blink_off_len: actual=%0d required=12", n); end
        checks++;
        if (bus.led !== 4'b1111) begin errors++; $display("[TB] FAIL blink_relit: actual=%b required=1111", bus.led); end
    endtask

    task automatic test_load_priority();
        bus.mode_load = 1'b1; bus.mode_in = 2'd0; bus.mode_next = 1'b1;
        @(negedge clk);
        bus.mode_load = 1'b0; bus.mode_next = 1'b0;
        checks++;
        if (bus.mode !== 2'd0) begin errors++; $display("[TB] FAIL load_priority_mode: actual=%0d required=0", bus.mode); end
        checks++;
        if (bus.led !== 4'b1111) begin errors++; $display("[TB] FAIL load_led_latency: actual=%b required=1111", bus.led); end
        @(negedge clk);
        checks++;
        if (bus.led !== 4'b0000) begin errors++; $display("[TB] FAIL load_off_led: actual=%b required=0000", bus.led); end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.mode_load = 1'b1; bus.mode_in = 2'd3;
        @(negedge clk);
        bus.mode_load = 1'b0; bus.mode_next = 1'b1;
        checks++;
        if (bus.mode !== 2'd3) begin errors++; $display("[TB] FAIL b2b_load3: actual=%0d required=3", bus.mode); end
        @(negedge clk);
        bus.mode_next = 1'b0;
        checks++;
        if (bus.mode !== 2'd0) begin errors++; $display("[TB] FAIL b2b_wrap: actual=%0d required=0", bus.mode); end
        bus.mode_load = 1'b1; bus.mode_in = 2'd2;
        @(negedge clk);
        bus.mode_load = 1'b0;
        repeat (5) @(negedge clk);
        bus.mode_load = 1'b1;
        @(negedge clk);
        bus.mode_load = 1'b0;
        checks++;
        if (bus.mode !== 2'd2) begin errors++; $display("[TB] FAIL b2b_reload_mode: actual=%0d required=2", bus.mode); end
        wait_change(4'b0001, n);
        checks++;
        if (n != 9) begin errors++; $display("[TB] FAIL reload_restart_gap: actual=%0d required=9", n); end
        checks++;
        if (bus.led !== 4'b0010) begin errors++; $display("[TB] FAIL reload_pattern: actual=%b required=0010", bus.led); end
    endtask

    task automatic test_pause();
        int n;
        bus.pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (bus.led !== 4'b0010) begin errors++; $display("[TB] FAIL pause_led: actual=%b required=0010", bus.led); end
            checks++;
            if (bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL pause_tick: actual=%b required=0", bus.tick); end
        end
        bus.pause = 1'b0;
        wait_change(4'b0010, n);
        checks++;
        if (n != 8) begin errors++; $display("[TB] FAIL pause_resume_gap: actual=%0d required=8", n); end
        checks++;
        if (bus.led !== 4'b0100) begin errors++; $display("[TB] FAIL pause_resume_led: actual=%b required=0100", bus.led); end
        bus.pause = 1'b1; bus.mode_next = 1'b1;
        @(negedge clk);
        bus.mode_next = 1'b0;
        checks++;
        if (bus.mode !== 2'd3) begin errors++; $display("[TB] FAIL pause_mode_change: actual=%0d required=3", bus.mode); end
        repeat (15) @(negedge clk);
        checks++;
        if (bus.led !== 4'b1111) begin errors++; $display("[TB] FAIL pause_blink_hold: actual=%b required=1111", bus.led); end
        bus.pause = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        bus.mode_load = 1'b1; bus.mode_in = 2'd1;
        @(negedge clk);
        bus.mode_load = 1'b0;
        repeat (21) @(negedge clk);
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            if (bus.led === 4'hF) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL breathe_level5_lit: actual=%b required=1111", bus.led); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.led !== 4'b0000) begin errors++; $display("[TB] FAIL async_reset_led: actual=%b required=0000", bus.led); end
        checks++;
        if (bus.mode !== 2'd1) begin errors++; $display("[TB] FAIL async_reset_mode: actual=%0d required=1", bus.mode); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.led !== 4'b0000) begin errors++; $display("[TB] FAIL restart_level0_led: actual=%b required=0000", bus.led); end
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        bus.mode_next = 1'b0; bus.mode_load = 1'b0; bus.mode_in = 2'd0; bus.pause = 1'b0;
        $display("[TB] starting led_pattern_sequencer bench");
        test_reset();
        test_run();
        test_blink();
        test_load_priority();
        test_back_to_back();
        test_pause();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
